univ_shift_seq: RTL

Sequenced universal shift register: a parametrised N-bit register that executes multi-step shift, rotate and load commands under a start/busy/done handshake. One step is applied per clock, and the register counts down a programmable amount. Serial inputs are sampled live on every step, so the block can stream bits in and out. It is the next-generation replacement for the single-step universal shift register in the datapath, and sits between the control FSMs and the serial I/O lanes.

---
 rtl/univ_shift_pkg.sv | 43 ++++
 rtl/univ_shift_step.sv | 41 ++++
 rtl/univ_shift_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/univ_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_pkg
//  Purpose  : Shared definitions for the sequenced universal shift register.
//             Holds the command encodings, the control state enum and a
//             helper that classifies commands as multi-step or single-cycle.
//  Config   : USR_ARITH_EN - when defined, MODE_ASR counts as a step command.
//  Revision : 1.0 - initial release
// ============================================================================
package univ_shift_pkg;

  // Command encodings carried on the mode input.
  localparam logic [2:0] MODE_NOP  = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for commands that consume RUN cycles when the amount is non-zero.
  // Without the arithmetic option, MODE_ASR falls into the NOP class.
  function automatic logic is_step_mode(input logic [2:0] m);
    logic r;
    case (m)
      MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL: r = 1'b1;
`ifdef USR_ARITH_EN
      MODE_ASR: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/univ_shift_step.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_step
//  Purpose  : Combinational single-step next-value function of the universal
//             shift register. Non-step commands return the input unchanged.
//  Ports    : q_i      - current register value
//             mode_i   - latched command
//             msb_i    - serial-in for right shift
//             lsb_i    - serial-in for left shift
//             q_next_o - value after one step
//  Config   : USR_ARITH_EN - builds the sign-replicating right shift.
//  Revision : 1.0 - initial release
// ============================================================================
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q_i,
  input  logic [2:0]   mode_i,
  input  logic         msb_i,
  input  logic         lsb_i,
  output logic [N-1:0] q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case (mode_i)
      MODE_SHR: q_next_o = {msb_i, q_i[N-1:1]};
      MODE_SHL: q_next_o = {q_i[N-2:0], lsb_i};
      MODE_ROR: q_next_o = {q_i[0], q_i[N-1:1]};
      MODE_ROL: q_next_o = {q_i[N-2:0], q_i[N-1]};
`ifdef USR_ARITH_EN
      MODE_ASR: q_next_o = {q_i[N-1], q_i[N-1:1]};
`endif
      default:  q_next_o = q_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/univ_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_seq
//  Purpose  : Sequenced universal shift register. Accepts a command under a
//             start/busy/done handshake and applies one shift/rotate step per
//             clock for a programmable count. Loads and NOPs finish at once.
//  Ports    : clk, reset_n (async, active-low)
//             I        - parallel load data      (sampled at accept)
//             MSB, LSB - serial inputs           (sampled every step)
//             mode,amt - command and step count  (sampled at accept)
//             start    - command request; abort - cancel a running command
//             busy     - high while running; done - one-cycle completion
//             Q        - register; so_msb/so_lsb - taps of Q[N-1]/Q[0]
//  Config   : USR_ARITH_EN - enables arithmetic right shift on mode 110.
//  Revision : 1.0 - initial release
// ============================================================================
module univ_shift_seq
  import univ_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  I,
  input  logic          MSB,
  input  logic          LSB,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  Q,
  output logic          so_msb,
  output logic          so_lsb
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic [2:0]    mode_q,  mode_d;
  logic [N-1:0]  reg_q,   reg_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic [N-1:0]  w_step;
  logic          w_accept;

  univ_shift_step #(.N(N)) u_step (
    .q_i      (reg_q),
    .mode_i   (mode_q),
    .msb_i    (MSB),
    .lsb_i    (LSB),
    .q_next_o (w_step)
  );

  // abort in any state suppresses acceptance for that cycle.
  assign w_accept = start && !abort && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    reg_d   = reg_q;

    case (state_q)
      RUN: begin
        if (abort) begin
          // Leave with the partial result; no step, no done pulse.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          reg_d = w_step;
          cnt_d = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE otherwise falls back to IDLE.
        state_d = IDLE;
        if (w_accept) begin
          mode_d = mode;
          if (mode == MODE_LOAD) begin
            reg_d = I;
          end
          if (is_step_mode(mode) && (amt != '0)) begin
            state_d = RUN;
            cnt_d   = amt;
          end else begin
            state_d = DONE;
          end
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_NOP;
      reg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      reg_q   <= reg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Q      = reg_q;
  assign so_msb = reg_q[N-1];
  assign so_lsb = reg_q[0];

endmodule
`default_nettype wire
